pwm_shadow_bank: RTL and testbench

Multi-channel, double-buffered register bank for the PWM datapath: holds `CHANNELS` compare/period values of `WIDTH` bits each. Software/bus writes land in a per-channel buffer stage. Buffered values move to the active outputs only at a selected PWM event, or immediately while the PWM is off, so the counter never sees a half-updated set of values. It sits between the register interface and the PWM comparators and generalises the single 16-bit masked register.

---
 rtl/pwm_shadow_bank.sv | 102 ++++++++++
 tb/tb_pwm_shadow_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_shadow_bank.sv
// pwm_shadow_bank: multi-channel double-buffered compare/period register bank.
// Bus writes land in a per-channel shadow buffer. Buffered values move to the
// active outputs together, either at a selected PWM event or immediately while
// the PWM is off, so the comparators never see a half-updated set of values.
//
// Optional feature macro: PWM_SHADOW_LOCK_EN adds the 'lock' input, which
// holds off all transfers while high.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   pwm_onoff    0 = PWM off (transfer immediately), 1 = PWM on
//   load_mode    0 immediate, 1 zero_event, 2 top_event, 3 either event
//   zero_event   pulse: PWM counter at zero
//   top_event    pulse: PWM counter at top
//   wr_en        per-channel write strobe
//   wr_data      per-channel write data, channel i at [i*WIDTH +: WIDTH]
//   clr_overrun  clear all overrun flags
//   lock         (PWM_SHADOW_LOCK_EN only) block transfers while high
//   reg_out      active values, same packing as wr_data
//   pending      shadow holds a value not yet transferred
//   overrun      sticky: a pending value was overwritten before transfer
//   load_strobe  one-cycle pulse after any channel transferred
module pwm_shadow_bank #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwm_onoff,
    input  logic [1:0]                load_mode,
    input  logic                      zero_event,
    input  logic                      top_event,
    input  logic [CHANNELS-1:0]       wr_en,
    input  logic [CHANNELS*WIDTH-1:0] wr_data,
    input  logic                      clr_overrun,
`ifdef PWM_SHADOW_LOCK_EN
    input  logic                      lock,
`endif
    output logic [CHANNELS*WIDTH-1:0] reg_out,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       overrun,
    output logic                      load_strobe
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic                trig_c;
    logic                lock_c;
    logic                xfer_c;
    logic [CHANNELS-1:0] move_c;

`ifdef PWM_SHADOW_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    // Common transfer decision; each pending channel moves when it is true.
    always_comb begin
        trig_c = 1'b0;
        case (load_mode)
            2'd0:    trig_c = 1'b1;
            2'd1:    trig_c = zero_event;
            2'd2:    trig_c = top_event;
            default: trig_c = zero_event | top_event;
        endcase
        xfer_c = (~pwm_onoff | trig_c) & ~lock_c;
        move_c = {CHANNELS{xfer_c}} & pending;
    end

    // Shadow, active and status registers. A transfer always takes the old
    // shadow value; a coincident write is captured and stays pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i]                 <= RST_VAL;
                reg_out[i*WIDTH +: WIDTH]   <= RST_VAL;
            end
            pending     <= '0;
            overrun     <= '0;
            load_strobe <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en[i]) begin
                    shadow_q[i] <= wr_data[i*WIDTH +: WIDTH];
                end
                if (move_c[i]) begin
                    reg_out[i*WIDTH +: WIDTH] <= shadow_q[i];
                end
            end
            pending     <= wr_en | (pending & ~move_c);
            // Set beats clear when both happen in the same cycle.
            overrun     <= (wr_en & pending & ~move_c)
                         | (overrun & ~{CHANNELS{clr_overrun}});
            load_strobe <= |move_c;
        end
    end

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// Bench for pwm_shadow_bank: a reference model predicts the registered
// outputs for every applied cycle and queues them; a monitor compares them
// against the DUT after each rising edge. Directed sequences add constant
// checks for the documented scenarios; random traffic follows.
module tb_pwm_shadow_bank;

    localparam int unsigned W  = 16;
    localparam int unsigned CH = 4;
    localparam int unsigned RV = 32'h0010;

    typedef struct packed {
        logic [CH*W-1:0] r;
        logic [CH-1:0]   p;
        logic [CH-1:0]   o;
        logic            s;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            pwm_onoff;
    logic [1:0]      load_mode;
    logic            zero_event;
    logic            top_event;
    logic [CH-1:0]   wr_en;
    logic [CH*W-1:0] wr_data;
    logic            clr_overrun;
    logic            lock;
    logic [CH*W-1:0] reg_out;
    logic [CH-1:0]   pending;
    logic [CH-1:0]   overrun;
    logic            load_strobe;

    int n_vec = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    // model state
    logic [W-1:0] m_buf [CH];
    logic [W-1:0] m_reg [CH];
    logic         m_pend[CH];
    logic         m_ovr [CH];
    logic         m_strb;

    pwm_shadow_bank #(.WIDTH(W), .CHANNELS(CH), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .pwm_onoff(pwm_onoff), .load_mode(load_mode),
        .zero_event(zero_event), .top_event(top_event), .wr_en(wr_en),
        .wr_data(wr_data), .clr_overrun(clr_overrun),
`ifdef PWM_SHADOW_LOCK_EN
        .lock(lock),
`endif
        .reg_out(reg_out), .pending(pending), .overrun(overrun),
        .load_strobe(load_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Behavioural model: one clock edge worth of the register bank rules.
    task automatic model_step(input logic rst, input logic on, input logic [1:0] mode,
                              input logic z, input logic t, input logic lk,
                              input logic [CH-1:0] wr, input logic [CH*W-1:0] d,
                              input logic clr);
        logic go;
        logic any;
        logic moving;
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_buf[i] = W'(RV); m_reg[i] = W'(RV);
                m_pend[i] = 1'b0;  m_ovr[i] = 1'b0;
            end
            m_strb = 1'b0;
        end else begin
            go = 1'b0;
            if (!on) go = 1'b1;
            if (mode == 2'd0) go = 1'b1;
            if ((mode == 2'd1 || mode == 2'd3) && z) go = 1'b1;
            if ((mode == 2'd2 || mode == 2'd3) && t) go = 1'b1;
`ifdef PWM_SHADOW_LOCK_EN
            if (lk) go = 1'b0;
`endif
            any = 1'b0;
            for (int i = 0; i < CH; i++) begin
                moving = go && m_pend[i];
                if (moving) begin
                    m_reg[i] = m_buf[i];
                    any = 1'b1;
                end
                if (wr[i] && m_pend[i] && !moving) m_ovr[i] = 1'b1;
                else if (clr)                       m_ovr[i] = 1'b0;
                if (wr[i]) begin
                    m_buf[i]  = d[i*W +: W];
                    m_pend[i] = 1'b1;
                end else if (moving) begin
                    m_pend[i] = 1'b0;
                end
            end
            m_strb = any;
        end
        for (int i = 0; i < CH; i++) begin
            e.r[i*W +: W] = m_reg[i];
            e.p[i] = m_pend[i];
            e.o[i] = m_ovr[i];
        end
        e.s = m_strb;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the prediction.
    task automatic apply(input logic rst, input logic on, input logic [1:0] mode,
                         input logic z, input logic t, input logic lk,
                         input logic [CH-1:0] wr, input logic [CH*W-1:0] d,
                         input logic clr);
        @(negedge clk);
        reset = rst; pwm_onoff = on; load_mode = mode; zero_event = z;
        top_event = t; lock = lk; wr_en = wr; wr_data = d; clr_overrun = clr;
        model_step(rst, on, mode, z, t, lk, wr, d, clr);
    endtask

    // Directed constant check, sampled after the edge that follows apply().
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [CH*W-1:0] one(input int ch, input logic [W-1:0] v);
        logic [CH*W-1:0] d;
        d = '0;
        d[ch*W +: W] = v;
        return d;
    endfunction

    // Monitor: every cycle with a prediction queued, compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (reg_out !== e.r || pending !== e.p || overrun !== e.o ||
                    load_strobe !== e.s) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got reg=%h pend=%b ovr=%b strb=%b expected reg=%h pend=%b ovr=%b strb=%b",
                             $time, reg_out, pending, overrun, load_strobe, e.r, e.p, e.o, e.s);
                end
            end
        end
    end

    initial begin
        logic [CH*W-1:0] d;
        logic [CH-1:0]   wr;
        reset = 1'b0; pwm_onoff = 1'b0; load_mode = 2'd0; zero_event = 1'b0;
        top_event = 1'b0; lock = 1'b0; wr_en = '0; wr_data = '0; clr_overrun = 1'b0;

        // Reset with pending traffic on the inputs: reset must win.
        apply(0, 0, 0, 0, 0, 0, 4'hF, {4{16'hFFFF}}, 0);
        apply(0, 0, 0, 0, 0, 0, 4'h0, '0, 0);
        settle();
        chk("reset_reg_out", 32'(reg_out[31:0]), 32'h0010_0010);
        chk("reset_reg_out_hi", 32'(reg_out[63:32]), 32'h0010_0010);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);

        // PWM off: one cycle from capture to active.
        apply(1, 0, 1, 0, 0, 0, 4'h0, '0, 0);
        apply(1, 0, 1, 0, 0, 0, 4'h1, one(0, 16'h1234), 0);
        settle();
        chk("off_pending_set", 32'(pending[0]), 32'h1);
        chk("off_reg_held", 32'(reg_out[15:0]), 32'h0010);
        apply(1, 0, 1, 0, 0, 0, 4'h0, '0, 0);
        settle();
        chk("off_reg_update", 32'(reg_out[15:0]), 32'h1234);
        chk("off_pending_clr", 32'(pending[0]), 32'h0);
        chk("off_strobe", 32'(load_strobe), 32'h1);

        // Zero mode, PWM on: top_event ignored, zero_event transfers.
        apply(1, 1, 1, 0, 0, 0, 4'h2, one(1, 16'h00FF), 0);
        apply(1, 1, 1, 0, 1, 0, 4'h0, '0, 0);
        settle();
        chk("zero_top_ignored", 32'(reg_out[31:16]), 32'h0010);
        chk("zero_strobe_low", 32'(load_strobe), 32'h0);
        apply(1, 1, 1, 1, 0, 0, 4'h0, '0, 0);
        settle();
        chk("zero_update", 32'(reg_out[31:16]), 32'h00FF);
        chk("zero_pending_clr", 32'(pending[1]), 32'h0);

        // Write coincident with the event: old value moves, new one waits.
        apply(1, 1, 1, 0, 0, 0, 4'h4, one(2, 16'h0AAA), 0);
        apply(1, 1, 1, 1, 0, 0, 4'h4, one(2, 16'h0BBB), 0);
        settle();
        chk("coinc_old_moves", 32'(reg_out[47:32]), 32'h0AAA);
        chk("coinc_pending", 32'(pending[2]), 32'h1);
        chk("coinc_no_overrun", 32'(overrun[2]), 32'h0);
        apply(1, 1, 1, 1, 0, 0, 4'h0, '0, 0);
        settle();
        chk("coinc_new_moves", 32'(reg_out[47:32]), 32'h0BBB);

        // Overrun, then transfer of the latest value, then clear.
        apply(1, 1, 1, 0, 0, 0, 4'h8, one(3, 16'h0001), 0);
        apply(1, 1, 1, 0, 0, 0, 4'h8, one(3, 16'h0002), 0);
        settle();
        chk("ovr_set", 32'(overrun[3]), 32'h1);
        apply(1, 1, 1, 1, 0, 0, 4'h0, '0, 0);
        settle();
        chk("ovr_latest_moves", 32'(reg_out[63:48]), 32'h0002);
        chk("ovr_sticky", 32'(overrun[3]), 32'h1);
        apply(1, 1, 1, 0, 0, 0, 4'h0, '0, 1);
        settle();
        chk("ovr_cleared", 32'(overrun[3]), 32'h0);

`ifdef PWM_SHADOW_LOCK_EN
        // Lock holds two staged channels; release at the next event only.
        apply(1, 1, 1, 0, 0, 1, 4'h3, one(0, 16'h0100) | one(1, 16'h0200), 0);
        apply(1, 1, 1, 1, 0, 1, 4'h0, '0, 0);
        settle();
        chk("lock_hold_ch0", 32'(reg_out[15:0]), 32'h1234);
        chk("lock_hold_ch1", 32'(reg_out[31:16]), 32'h00FF);
        apply(1, 1, 1, 0, 0, 0, 4'h0, '0, 0);
        settle();
        chk("unlock_no_xfer", 32'(reg_out[15:0]), 32'h1234);
        apply(1, 1, 1, 1, 0, 0, 4'h0, '0, 0);
        settle();
        chk("unlock_both", 32'(reg_out[31:0]), 32'h0200_0100);
        chk("unlock_strobe", 32'(load_strobe), 32'h1);
        apply(1, 1, 1, 0, 0, 0, 4'h0, '0, 0);
        settle();
        chk("unlock_strobe_single", 32'(load_strobe), 32'h0);
`endif

        // Random traffic checked purely by the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++) d[i*W +: W] = W'($urandom);
            wr = CH'($urandom);
            for (int i = 0; i < CH; i++) if ($urandom_range(0, 2) != 0) wr[i] = 1'b0;
            apply(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  wr, d,
                  ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
